// File: rtl/pdm_dimmer_mc_if.sv
// Control and LED-side signal bundle for the multi-channel PDM dimmer.
// The master drives the step/select/mode controls; the dimmer (slave) drives the LED outputs.
interface pdm_dimmer_mc_if #(
    parameter int NUM_CH = 4,
    parameter int LVL_W  = 4,
    parameter int CSEL_W = 2
);
    logic                      step;
    logic [CSEL_W-1:0]         ch_sel;
    logic                      mode;
    logic [NUM_CH-1:0]         pdm_o;
    logic [NUM_CH*LVL_W-1:0]   level_o;
    logic [NUM_CH-1:0]         dwn_o;

    modport master (
        output step,
        output ch_sel,
        output mode,
        input  pdm_o,
        input  level_o,
        input  dwn_o
    );

    modport slave (
        input  step,
        input  ch_sel,
        input  mode,
        output pdm_o,
        output level_o,
        output dwn_o
    );
endinterface

// File: rtl/pdm_dimmer_mc.sv
// Multi-channel LED dimmer: per-channel triangular level ramp feeding a first-order
// sigma-delta PDM modulator, advanced by a step pulse (manual) or a prescaler tick (auto).
module pdm_dimmer_mc #(
    parameter int NUM_CH   = 4,
    parameter int LVL_W    = 4,
    parameter int DUTY_W   = 15,
    parameter int PRESCALE = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    pdm_dimmer_mc_if.slave   bus
);
    localparam int CSEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PS_W   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [LVL_W-1:0] LVL_MAX = '1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick;

    // Held at zero in manual mode so the first auto advance is a full period away.
    assign tick = bus.mode && (ps_q == PS_LAST);

    always_comb begin
        ps_d = ps_q;
        if (!bus.mode) begin
            ps_d = '0;
        end else if (tick) begin
            ps_d = '0;
        end else begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    logic [NUM_CH-1:0]       pdm_vec;
    logic [NUM_CH-1:0]       dwn_vec;
    logic [NUM_CH*LVL_W-1:0] lvl_vec;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic              adv;
        logic [LVL_W-1:0]  lvl_q, lvl_d;
        logic              dwn_q, dwn_d;
        logic [DUTY_W-1:0] duty;
        logic [DUTY_W-1:0] acc_q, acc_d;
        logic [DUTY_W:0]   sum;
        logic              pdm_q, pdm_d;

        // Out-of-range selects never match any channel index, so they are ignored.
        assign adv = bus.mode ? tick
                              : (bus.step && (bus.ch_sel == CSEL_W'(gi)));

        always_comb begin
            lvl_d = lvl_q;
            dwn_d = dwn_q;
            if (adv) begin
                if (!dwn_q) begin
                    lvl_d = lvl_q + LVL_W'(1);
                    if (lvl_d == LVL_MAX) begin
                        dwn_d = 1'b1;
                    end
                end else begin
                    lvl_d = lvl_q - LVL_W'(1);
                    if (lvl_d == '0) begin
                        dwn_d = 1'b0;
                    end
                end
            end
        end

        // Level occupies the duty MSBs; accumulator keeps its residue across level changes.
        assign duty  = DUTY_W'(lvl_q) << (DUTY_W - LVL_W);
        assign sum   = {1'b0, acc_q} + {1'b0, duty};
        assign acc_d = sum[DUTY_W-1:0];
        assign pdm_d = sum[DUTY_W];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lvl_q <= '0;
                dwn_q <= 1'b0;
                acc_q <= '0;
                pdm_q <= 1'b0;
            end else begin
                lvl_q <= lvl_d;
                dwn_q <= dwn_d;
                acc_q <= acc_d;
                pdm_q <= pdm_d;
            end
        end

        assign pdm_vec[gi]                  = pdm_q;
        assign dwn_vec[gi]                  = dwn_q;
        assign lvl_vec[gi*LVL_W +: LVL_W]   = lvl_q;
    end

    assign bus.pdm_o   = pdm_vec;
    assign bus.dwn_o   = dwn_vec;
    assign bus.level_o = lvl_vec;
endmodule

// File: doc/pdm_dimmer_mc.md
Name: pdm_dimmer_mc

Overview:
- Multi-channel LED dimmer. Generalises the single-channel push-button PDM ramp test to NUM_CH independent channels.
- Each channel has its own triangular brightness level counter (up to max, then down to 0, repeat) and its own first-order sigma-delta PDM modulator.
- Two modes. Manual mode: a one-cycle step pulse (from a PB release detector) advances the selected channel. Auto "breathing" mode: an internal prescaler advances all channels.
- Sits between the PB/rst synchroniser front end and the board LEDs.

Parameters:
NUM_CH, 4, number of independent PDM channels (1..16)
LVL_W, 4, width of per-channel level counter; max level LVL_MAX = 2^LVL_W-1
DUTY_W, 15, PDM duty/accumulator width; duty = {level, (DUTY_W-LVL_W) zeros}
PRESCALE, 1000000, auto-mode advance period in clk cycles (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset; asynchronous, active-high, clears all state
step  input  1  one-cycle advance pulse (manual mode)
ch_sel  input  max(1,$clog2(NUM_CH))  channel that step advances
mode  input  1  0 = manual, 1 = auto breathing
pdm_o  output  NUM_CH  PDM bitstream per channel, registered
level_o  output  NUM_CH*LVL_W  per-channel level, ch i at [i*LVL_W +: LVL_W]
dwn_o  output  NUM_CH  per-channel direction flag, 1 = ramping down

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-high (rst).
- Reset values: level_o = 0, dwn_o = 0, pdm_o = 0, all accumulators = 0, prescaler = 0.
- Advance event, per channel, on clock edge:
  - Manual mode (mode = 0): adv[i] = step & (ch_sel == i).
  - Auto mode (mode = 1): adv[i] = tick for all i; step is ignored.
- ch_sel >= NUM_CH (NUM_CH not a power of 2): step is ignored, no channel changes.
- Advance rule, evaluated on current state:
  - dwn = 0: level <= level+1; dwn <= 1 if level+1 == LVL_MAX.
  - dwn = 1: level <= level-1; dwn <= 0 if level-1 == 0.
  - Resulting sequence: 0, 1, …, LVL_MAX, LVL_MAX-1, …, 0, 1, …
  - Never wraps.
- Level and dwn update in the cycle after the step/tick edge (1-cycle latency).
- Prescaler:
  - Counts 0..PRESCALE-1 only while mode = 1. tick = 1 for the single cycle where count == PRESCALE-1, then count wraps to 0.
  - While mode = 0, count is held at 0.
  - Result: the first tick after entering auto mode is PRESCALE cycles later.
- Mode switching keeps levels and dwn flags unchanged.
- PDM, per channel, every cycle:
  - sum[DUTY_W:0] = acc + duty.
  - acc <= sum[DUTY_W-1:0]; pdm_o[i] <= sum[DUTY_W].
  - Ones-density = duty / 2^DUTY_W.
  - Level 0 gives a constant 0 output.
- A duty change takes effect in the accumulator the cycle after the level changes. The accumulator is not cleared on duty change.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Operation resumes from level 0, up direction.

Test Plan:
- Reset check: assert rst for 3 cycles with step = 1 -> level_o = 0, dwn_o = 0, pdm_o = 0 throughout; after release, outputs stay 0 with no step.
- Manual ramp: mode = 0, ch_sel = 1, 16 step pulses spaced 10 cycles apart ->
  - ch1 level goes 1..15; dwn_o[1] = 1 after the 15th step.
  - Next step gives 14; step 30 gives 0 with dwn_o[1] = 0; step 31 gives 1.
  - Other channels stay 0.
- PDM density: set ch0 to level 8 (duty = 16384, DUTY_W = 15) ->
  - pdm_o[0] alternates 0/1 every cycle.
  - Over 32768 cycles, exactly 16384 ones.
  - Level 1 gives exactly 1 one per 16 cycles.
- Auto mode: PRESCALE = 4, mode = 1 ->
  - All channels advance together every 4 cycles, first advance 4 cycles after mode rises.
  - Reach 15 after 60 cycles, 0 after 120 cycles.
  - step pulses have no effect.
- Range/select: NUM_CH = 3, ch_sel = 3, step pulses -> no level change on any channel; ch_sel = 2 -> only ch2 advances.
- Reset mid-ramp: ch0 at level 9 with dwn = 1, assert rst asynchronously between edges -> level_o, dwn_o and pdm_o clear immediately; the next step after release gives level 1.
